// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the F/D/E/M/W pipeline registers: combines decode hazards,
// a multiply/divide busy window and CP0 exceptions into PC/D/E controls plus a stall counter.
module pipe_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lu_hazard,
  input  logic        d_is_md,
  input  logic        e_md_start,
  input  logic        e_md_is_div,
  input  logic        exc_req,
  output logic        pc_we,
  output logic        d_we,
  output logic        e_clr,
  output logic        md_start,
  output logic        md_busy,
  output logic        stall,
  output logic [31:0] stall_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  // An exception flushes the E-stage instruction, so its MDU operation must never launch.
  assign md_start = e_md_start & ~exc_req;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // NOTE: next-state values are defaulted first so no path leaves them unassigned (no latch).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (md_start) begin
          state_n = BUSY;
          cnt_n   = e_md_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        // A running operation belongs to an older committed instruction: exc_req and
        // stray start strobes leave it alone.
        if (cnt == CNT_ONE) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign md_busy = (state == BUSY);

  // The e_md_start term covers the start cycle, before md_busy has been registered.
  assign stall = ~exc_req & (lu_hazard | (d_is_md & (md_busy | e_md_start)));

  // During an exception stall is 0, so the PC loads the handler and nothing is cleared here.
  assign pc_we = ~stall;
  assign d_we  = ~stall;
  assign e_clr = stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: combinational vector table, directed multi-cycle
// sequences and a randomized run against a cycle-numbered reference model.
module tb_pipe_stall_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        lu_hazard, d_is_md, e_md_start, e_md_is_div, exc_req;
  logic        pc_we, d_we, e_clr, md_start, md_busy, stall;
  logic [31:0] stall_cnt;

  pipe_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .lu_hazard  (lu_hazard),
    .d_is_md    (d_is_md),
    .e_md_start (e_md_start),
    .e_md_is_div(e_md_is_div),
    .exc_req    (exc_req),
    .pc_we      (pc_we),
    .d_we       (d_we),
    .e_clr      (e_clr),
    .md_start   (md_start),
    .md_busy    (md_busy),
    .stall      (stall),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the busy window is the set of cycle numbers (start, start+N],
  // so md_busy is simply "current cycle <= last busy cycle".
  longint      cyc;
  longint      busy_end;
  logic [31:0] cnt_exp;

  logic        obs_stall, obs_busy, obs_dwe, obs_pcwe, obs_eclr, obs_ms;
  logic [31:0] obs_cnt;

  task automatic model_reset();
    cyc      = 0;
    busy_end = -1;
    cnt_exp  = '0;
  endtask

  task automatic step(input logic lu, input logic dmd, input logic es, input logic ediv,
                      input logic exc);
    logic exp_busy, exp_stall;
    @(negedge clk);
    lu_hazard   = lu;
    d_is_md     = dmd;
    e_md_start  = es;
    e_md_is_div = ediv;
    exc_req     = exc;
    #1;
    exp_busy  = (cyc <= busy_end);
    exp_stall = !exc && (lu || (dmd && (exp_busy || es)));
    check("md_busy",   md_busy,   exp_busy);
    check("stall",     stall,     exp_stall);
    check("pc_we",     pc_we,     !exp_stall);
    check("d_we",      d_we,      !exp_stall);
    check("e_clr",     e_clr,     exp_stall);
    check("md_start",  md_start,  es && !exc);
    check("stall_cnt", stall_cnt, cnt_exp);
    obs_stall = stall;
    obs_busy  = md_busy;
    obs_dwe   = d_we;
    obs_pcwe  = pc_we;
    obs_eclr  = e_clr;
    obs_ms    = md_start;
    obs_cnt   = stall_cnt;
    @(posedge clk);
    if (exp_stall) cnt_exp = cnt_exp + 32'd1;
    if (!exp_busy && es && !exc) busy_end = cyc + (ediv ? DIV_N : MULT_N);
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       lu, dmd, es, ediv, exc;
    logic [4:0] exp;  // {pc_we, d_we, e_clr, md_start, stall}
  } vec_t;

  vec_t vecs[10];

  initial begin
    int sc, bc;
    reset       = 1'b1;
    lu_hazard   = 1'b0;
    d_is_md     = 1'b0;
    e_md_start  = 1'b0;
    e_md_is_div = 1'b0;
    exc_req     = 1'b0;
    model_reset();

    // Reset held: md_busy is forced 0, so outputs depend only on the inputs.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00101};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00111};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b11010};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b11000};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11000};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'b11000};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00101};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00111};

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lu_hazard   = vecs[i].lu;
      d_is_md     = vecs[i].dmd;
      e_md_start  = vecs[i].es;
      e_md_is_div = vecs[i].ediv;
      exc_req     = vecs[i].exc;
      #1;
      check($sformatf("vec%0d_ctrl", i), {pc_we, d_we, e_clr, md_start, stall}, vecs[i].exp);
      check($sformatf("vec%0d_busy", i), md_busy, 1'b0);
      check($sformatf("vec%0d_cnt", i), stall_cnt, 32'd0);
    end
    @(negedge clk);
    lu_hazard  = 1'b0;
    d_is_md    = 1'b0;
    e_md_start = 1'b0;
    exc_req    = 1'b0;
    reset      = 1'b0;
    model_reset();

    // One load-use stall cycle.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lu_stall", {obs_pcwe, obs_dwe, obs_eclr}, 3'b001);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lu_release", {obs_pcwe, obs_dwe, obs_eclr}, 3'b110);
    check("lu_cnt", obs_cnt, 32'd1);

    // Multiply then divide with a dependent MDU instruction held in D.
    for (int d = 0; d < 2; d++) begin
      int n;
      n = (d == 1) ? DIV_N : MULT_N;
      apply_reset();
      step(1'b0, 1'b1, 1'b1, d[0], 1'b0);
      sc = int'(obs_stall);
      bc = int'(obs_busy);
      for (int k = 0; k < n; k++) begin
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        sc += int'(obs_stall);
        bc += int'(obs_busy);
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("md%0d_stall_cycles", d), sc, n + 1);
      check($sformatf("md%0d_busy_cycles", d), bc, n);
      check($sformatf("md%0d_issue_dwe", d), obs_dwe, 1'b1);
      check($sformatf("md%0d_stall_cnt", d), obs_cnt, n + 1);
    end

    // Start and exception together: the operation never launches.
    apply_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("exc_start_ms", obs_ms, 1'b0);
    check("exc_start_ctrl", {obs_pcwe, obs_dwe, obs_eclr}, 3'b110);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("exc_start_busy", obs_busy, 1'b0);
    check("exc_start_nostall", obs_stall, 1'b0);

    // Exception while a multiply is busy (cnt=3): no stall that cycle, busy continues.
    apply_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("busy_exc_stall", obs_stall, 1'b0);
    check("busy_exc_busy", obs_busy, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("busy_after_exc_stall", obs_stall, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("busy_last_cycle", obs_busy, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("busy_fell", obs_busy, 1'b0);
    check("busy_fell_stall", obs_stall, 1'b0);

    // Asynchronous reset pulse in the middle of a divide, between clock edges.
    apply_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    e_md_start = 1'b0;
    reset      = 1'b1;
    #1;
    check("async_rst_busy", md_busy, 1'b0);
    check("async_rst_cnt", stall_cnt, 32'd0);
    check("async_rst_stall", stall, 1'b0);
    reset = 1'b0;
    model_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("post_rst_stall", obs_stall, 1'b0);

    // Counter wrap from all-ones.
    @(negedge clk);
    dut.stall_cnt = 32'hFFFF_FFFF;
    cnt_exp       = 32'hFFFF_FFFF;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_cnt", obs_cnt, 32'd0);

    // Randomized traffic against the model.
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(4) == 0, $urandom_range(2) == 0, $urandom_range(5) == 0,
           $urandom_range(1) == 1, $urandom_range(9) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
